// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - fetch-control bundle between decode and the program counter
interface program_counter_if #(
  parameter int I_ADDR_W = 12,
  parameter int DATA_W   = 8
);
  logic [I_ADDR_W-1:0] imar;
  logic [I_ADDR_W-1:0] address_immediate;
  logic                jump_branch_select;
  logic                immediate_select;
  logic                unconditional_branch;
  logic [DATA_W-1:0]   status_register;
  logic [2:0]          branch_condition;
  logic [I_ADDR_W-1:0] pc;

  modport master (
    output imar,
    output address_immediate,
    output jump_branch_select,
    output immediate_select,
    output unconditional_branch,
    output status_register,
    output branch_condition,
    input  pc
  );

  modport slave (
    input  imar,
    input  address_immediate,
    input  jump_branch_select,
    input  immediate_select,
    input  unconditional_branch,
    input  status_register,
    input  branch_condition,
    output pc
  );
endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - instruction-fetch PC: increment or jump/branch to imar/immediate target
module program_counter #(
  parameter int I_ADDR_W = 12,
  parameter int DATA_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  program_counter_if.slave      bus
);

  localparam int ZERO_FLAG     = 0;
  localparam int POSITIVE_FLAG = 1;
  localparam int CARRY_FLAG    = 2;
  localparam int OVERFLOW_FLAG = 3;

  typedef enum logic [2:0] {
    COND_ZERO             = 3'd0,
    COND_NOT_ZERO         = 3'd1,
    COND_POSITIVE         = 3'd2,
    COND_NEGATIVE         = 3'd3,
    COND_CARRY_SET        = 3'd4,
    COND_CARRY_CLEARED    = 3'd5,
    COND_OVERFLOW_SET     = 3'd6,
    COND_OVERFLOW_CLEARED = 3'd7
  } branch_condition_e;

  logic [I_ADDR_W-1:0] pc_q;
  logic [I_ADDR_W-1:0] pc_d;
  logic [I_ADDR_W-1:0] target;
  logic                cond_met;
  logic                take;
  branch_condition_e   cond;

  logic flag_z;
  logic flag_p;
  logic flag_c;
  logic flag_v;

  assign flag_z = bus.status_register[ZERO_FLAG];
  assign flag_p = bus.status_register[POSITIVE_FLAG];
  assign flag_c = bus.status_register[CARRY_FLAG];
  assign flag_v = bus.status_register[OVERFLOW_FLAG];

  // Upper status bits carry no branch meaning.
  logic unused_status;
  assign unused_status = ^bus.status_register[DATA_W-1:4];

  assign cond = branch_condition_e'(bus.branch_condition);

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      COND_ZERO:             cond_met = flag_z;
      COND_NOT_ZERO:         cond_met = ~flag_z;
      COND_POSITIVE:         cond_met = flag_p;
      COND_NEGATIVE:         cond_met = ~flag_p;
      COND_CARRY_SET:        cond_met = flag_c;
      COND_CARRY_CLEARED:    cond_met = ~flag_c;
      COND_OVERFLOW_SET:     cond_met = flag_v;
      COND_OVERFLOW_CLEARED: cond_met = ~flag_v;
      default:               cond_met = 1'b0;
    endcase
  end

  assign target = bus.immediate_select ? bus.address_immediate : bus.imar;
  assign take   = bus.jump_branch_select & (bus.unconditional_branch | cond_met);

  // Increment wraps naturally at 2^I_ADDR_W.
  assign pc_d = take ? target : pc_q + I_ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - vector table, reset sequences and random model check for program_counter
module tb_program_counter;

  logic clk;
  logic rst;

  program_counter_if #(.I_ADDR_W(12), .DATA_W(8)) bus ();

  program_counter #(.I_ADDR_W(12), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jbs;
    logic        isel;
    logic        unc;
    logic [2:0]  cond;
    logic [7:0]  st;
    logic [11:0] imar;
    logic [11:0] imm;
    logic [11:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   model_pc;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: pc=0x%03h expected 0x%03h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic jbs, input logic isel, input logic unc, input logic [2:0] cond,
                     input logic [7:0] st, input logic [11:0] imar, input logic [11:0] imm,
                     input logic [11:0] exp_pc);
    vec_t v;
    v.jbs = jbs; v.isel = isel; v.unc = unc; v.cond = cond; v.st = st;
    v.imar = imar; v.imm = imm; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic jbs, input logic isel, input logic unc, input logic [2:0] cond,
                       input logic [7:0] st, input logic [11:0] imar, input logic [11:0] imm);
    bus.jump_branch_select   = jbs;
    bus.immediate_select     = isel;
    bus.unconditional_branch = unc;
    bus.branch_condition     = cond;
    bus.status_register      = st;
    bus.imar                 = imar;
    bus.address_immediate    = imm;
  endtask

  // Condition code c tests flag bit c/2; even codes want it set, odd codes want it clear.
  function automatic bit model_met(input logic [2:0] c, input logic [7:0] st);
    int  idx;
    bit  f;
    idx = int'(c) / 2;
    f   = st[idx];
    return (int'(c) % 2 == 0) ? f : !f;
  endfunction

  function automatic int model_next(input int pc, input logic jbs, input logic isel, input logic unc,
                                    input logic [2:0] c, input logic [7:0] st,
                                    input logic [11:0] imar, input logic [11:0] imm);
    if (jbs && (unc || model_met(c, st)))
      return isel ? int'(imm) : int'(imar);
    return (pc + 1) % 4096;
  endfunction

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 3'd0, 8'h00, 12'h000, 12'h000);

    // Ten increments; uncond/cond junk with jbs=0 must be ignored.
    for (int i = 1; i <= 10; i++)
      add(0, 1, (i % 3 == 0), 3'(i), 8'hFF, 12'hABC, 12'hDEF, 12'(i));
    add(1, 1, 1, 3'd0, 8'h00, 12'h555, 12'h100, 12'h100);
    add(1, 0, 1, 3'd0, 8'h00, 12'h200, 12'h111, 12'h200);
    add(1, 1, 0, 3'd0, 8'h01, 12'hABC, 12'h300, 12'h300);
    add(1, 1, 0, 3'd0, 8'h00, 12'hABC, 12'h400, 12'h301);
    add(1, 1, 0, 3'd1, 8'h00, 12'hABC, 12'h310, 12'h310);
    add(1, 1, 0, 3'd1, 8'h01, 12'hABC, 12'h400, 12'h311);
    add(1, 1, 0, 3'd2, 8'h02, 12'hABC, 12'h320, 12'h320);
    add(1, 1, 0, 3'd2, 8'hFD, 12'hABC, 12'h400, 12'h321);
    add(1, 0, 0, 3'd3, 8'hFD, 12'h330, 12'h400, 12'h330);
    add(1, 0, 0, 3'd3, 8'h02, 12'h400, 12'h330, 12'h331);
    add(1, 1, 0, 3'd4, 8'h04, 12'hABC, 12'h340, 12'h340);
    add(1, 1, 0, 3'd4, 8'hFB, 12'hABC, 12'h400, 12'h341);
    add(1, 1, 0, 3'd5, 8'h00, 12'hABC, 12'h350, 12'h350);
    add(1, 1, 0, 3'd5, 8'h04, 12'hABC, 12'h400, 12'h351);
    add(1, 1, 0, 3'd6, 8'h08, 12'hABC, 12'h360, 12'h360);
    add(1, 1, 0, 3'd6, 8'hF7, 12'hABC, 12'h400, 12'h361);
    add(1, 1, 0, 3'd7, 8'hF7, 12'hABC, 12'h370, 12'h370);
    add(1, 1, 0, 3'd7, 8'h08, 12'hABC, 12'h400, 12'h371);
    add(1, 1, 1, 3'd0, 8'h00, 12'h000, 12'hFFF, 12'hFFF);
    add(0, 0, 0, 3'd0, 8'h00, 12'h000, 12'h000, 12'h000);
    add(0, 0, 0, 3'd0, 8'h00, 12'h000, 12'h000, 12'h001);
    add(1, 1, 1, 3'd0, 8'h00, 12'h000, 12'h123, 12'h123);
    add(1, 0, 1, 3'd1, 8'h01, 12'h456, 12'h000, 12'h456);
    add(1, 1, 1, 3'd2, 8'h00, 12'h000, 12'h789, 12'h789);
    add(0, 1, 1, 3'd0, 8'h01, 12'h000, 12'h222, 12'h78A);

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_async", bus.pc, 12'h000);
    @(posedge clk); #1;
    check("reset_hold", bus.pc, 12'h000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].jbs, vecs[i].isel, vecs[i].unc, vecs[i].cond, vecs[i].st, vecs[i].imar, vecs[i].imm);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), bus.pc, vecs[i].exp_pc);
    end

    // Mid-cycle reset pulse while pc=0x123.
    drive(1, 1, 1, 3'd0, 8'h00, 12'h000, 12'h123);
    @(posedge clk); #1;
    check("pre_reset_jump", bus.pc, 12'h123);
    drive(0, 0, 0, 3'd0, 8'h00, 12'h000, 12'h000);
    rst = 1'b1;
    #1 check("reset_midcycle", bus.pc, 12'h000);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_inc", bus.pc, 12'h001);

    // Reset held across an edge wins over a pending jump; release then jumps.
    drive(1, 1, 1, 3'd0, 8'h00, 12'h000, 12'h5A5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_over_jump", bus.pc, 12'h000);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_jump", bus.pc, 12'h5A5);
    model_pc = 'h5A5;

    for (int n = 0; n < 400; n++) begin
      logic        jbs, isel, unc;
      logic [2:0]  c;
      logic [7:0]  st;
      logic [11:0] im, ia;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        #1 check("rand_reset", bus.pc, 12'h000);
        #1 rst = 1'b0;
        model_pc = 0;
      end
      jbs  = 1'($urandom);
      isel = 1'($urandom);
      unc  = ($urandom_range(0, 3) == 0);
      c    = 3'($urandom);
      st   = 8'($urandom);
      ia   = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      im   = 12'($urandom);
      drive(jbs, isel, unc, c, st, ia, im);
      model_pc = model_next(model_pc, jbs, isel, unc, c, st, ia, im);
      @(posedge clk); #1;
      check($sformatf("rand%0d", n), bus.pc, 12'(model_pc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
